// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch button front end.
// The debounce default is also reused by the stopwatch top level.
package stopwatch_pkg;

    localparam int unsigned DEBOUNCE_DEFAULT = 32'd1000000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

endpackage

// File: rtl/button_debounce.sv
// One button channel: synchronizer chain, stable-level counter and debounce FSM.
// Produces a registered single-cycle press pulse and a clean held level.
module button_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 32'd2
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_n,
    output logic press,
    output logic held
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 32'd1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] MAX_CNT  = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_n_s;
    btn_state_t             state_r;
    btn_state_t             state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   press_nxt_s;
    logic                   press_r;
    logic                   held_r;

    assign sync_n_s = sync_r[SYNC_STAGES-1];
    assign press    = press_r;
    assign held     = held_r;

    // Next-state, counter and pulse decode for the debounce FSM
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        press_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!sync_n_s) begin
                    state_nxt_s = PRESS_WAIT;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (sync_n_s) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r == LAST_CNT) begin
                    state_nxt_s = PRESSED;
                    press_nxt_s = 1'b1;
                end else if (cnt_r != MAX_CNT) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            PRESSED: begin
                if (sync_n_s) begin
                    state_nxt_s = RELEASE_WAIT;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = PRESSED;
                end
            end
            RELEASE_WAIT: begin
                if (!sync_n_s) begin
                    state_nxt_s = PRESSED;
                end else if (cnt_r == LAST_CNT) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r != MAX_CNT) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Synchronizer, FSM state and registered outputs; reset refills the chain as released
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_r  <= {SYNC_STAGES{1'b1}};
            state_r <= IDLE;
            cnt_r   <= '0;
            press_r <= 1'b0;
            held_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], btn_n};
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            press_r <= press_nxt_s;
            held_r  <= (state_nxt_s == PRESSED) || (state_nxt_s == RELEASE_WAIT);
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Two independent debounced channels for the stopwatch S1/S2 buttons.
// Each channel yields a one-cycle press pulse and a held level.
module button_conditioner
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 32'd2
) (
    input  logic clk,
    input  logic resetn,
    input  logic S1,
    input  logic S2,
    output logic s1_press,
    output logic s2_press,
    output logic s1_held,
    output logic s2_held
);

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_s1 (
        .clk    (clk),
        .resetn (resetn),
        .btn_n  (S1),
        .press  (s1_press),
        .held   (s1_held)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_s2 (
        .clk    (clk),
        .resetn (resetn),
        .btn_n  (S2),
        .press  (s2_press),
        .held   (s2_held)
    );

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a run-length reference model predicts
// press pulses and held levels; a negedge monitor checks the DUT against them.
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic S1 = 1'b1;
    logic S2 = 1'b1;
    logic s1_press, s2_press, s1_held, s2_held;

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (SS)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .S1       (S1),
        .S2       (S2),
        .s1_press (s1_press),
        .s2_press (s2_press),
        .s1_held  (s1_held),
        .s2_held  (s2_held)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int exp_q[$];            // expected pulses, encoded as cycle*2 + channel

    // Reference model state: raw-sample delay line, run length of opposite level, pressed flag
    logic [SS-1:0] hist [2];
    int            run  [2];
    logic          m_held [2];
    logic          raw  [2];
    logic          seen;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            raw[0] = S1;
            raw[1] = S2;
            for (int ch = 0; ch < 2; ch++) begin
                if (!resetn) begin
                    hist[ch]   = '1;
                    run[ch]    = 0;
                    m_held[ch] = 1'b0;
                end else begin
                    seen     = hist[ch][SS-1];
                    hist[ch] = {hist[ch][SS-2:0], raw[ch]};
                    // a level change is accepted after D+1 consecutive opposite samples
                    if ((!seen) != m_held[ch]) run[ch]++;
                    else run[ch] = 0;
                    if (run[ch] == D + 1) begin
                        m_held[ch] = !m_held[ch];
                        run[ch]    = 0;
                        if (m_held[ch]) exp_q.push_back(cyc * 2 + ch);
                    end
                end
            end
        end
    end

    logic dut_press [2];
    logic dut_held  [2];
    int   got;

    initial begin
        forever begin
            @(negedge clk);
            dut_press[0] = s1_press;
            dut_press[1] = s2_press;
            dut_held[0]  = s1_held;
            dut_held[1]  = s2_held;
            for (int ch = 0; ch < 2; ch++) begin
                if (dut_press[ch] !== 1'b0) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL press_unexpected ch%0d cycle %0d: got pulse %b, required none", ch, cyc, dut_press[ch]);
                    end else begin
                        got = exp_q.pop_front();
                        if (got != cyc * 2 + ch || dut_press[ch] !== 1'b1) begin
                            n_bad++;
                            $display("FAIL press_timing ch%0d: got pulse at cycle %0d, required ch%0d at cycle %0d", ch, cyc, got % 2, got / 2);
                        end
                    end
                end
                n_cmp++;
                if (dut_held[ch] !== m_held[ch]) begin
                    n_bad++;
                    $display("FAIL held ch%0d cycle %0d: got %b, required %b", ch, cyc, dut_held[ch], m_held[ch]);
                end
            end
            while (exp_q.size() > 0 && exp_q[0] <= cyc * 2 + 1) begin
                got = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL press_missing ch%0d: got no pulse, required one at cycle %0d", got % 2, got / 2);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset for one edge, then idle
        resetn = 1'b0; S1 = 1'b1; S2 = 1'b1;
        wait_cyc(1);
        resetn = 1'b1;
        wait_cyc(20);

        // Clean S1 press and release
        S1 = 1'b0; wait_cyc(12);
        S1 = 1'b1; wait_cyc(12);

        // S2 bounce 0/1/0/1 every 2 cycles, then settles low
        S2 = 1'b0; wait_cyc(2);
        S2 = 1'b1; wait_cyc(2);
        S2 = 1'b0; wait_cyc(2);
        S2 = 1'b1; wait_cyc(2);
        S2 = 1'b0; wait_cyc(12);
        S2 = 1'b1; wait_cyc(12);

        // S1 release bounce
        S1 = 1'b0; wait_cyc(12);
        S1 = 1'b1; wait_cyc(2);
        S1 = 1'b0; wait_cyc(2);
        S1 = 1'b1; wait_cyc(12);

        // Simultaneous press
        S1 = 1'b0; S2 = 1'b0; wait_cyc(12);
        S1 = 1'b1; S2 = 1'b1; wait_cyc(12);

        // Simultaneous press aborted by reset, buttons held through reset release
        S1 = 1'b0; S2 = 1'b0; wait_cyc(3);
        resetn = 1'b0; wait_cyc(1);
        resetn = 1'b1; wait_cyc(12);
        S1 = 1'b1; S2 = 1'b1; wait_cyc(12);

        // Randomized bouncy traffic with occasional resets
        for (int i = 0; i < 80; i++) begin
            S1 = 1'($urandom_range(0, 1));
            S2 = 1'($urandom_range(0, 1));
            resetn = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
            if (!resetn) begin
                wait_cyc(1);
                resetn = 1'b1;
            end
            wait_cyc($urandom_range(1, 10));
        end

        S1 = 1'b1; S2 = 1'b1; resetn = 1'b1;
        wait_cyc(15);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pulses outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
